i2s_volume_ctrl: RTL

- Volume controller for the audio path. Turns the two board buttons (BTN_volminus, BTN_volplus) into a saturating volume level with debounce and press-and-hold auto-repeat.
- Drives the attenuation input of the I2S sample path: level plus a one-cycle change strobe for the Nios/PIO status readback.
- Sits in the clk25 domain next to the i2s_upsampler. Button inputs are raw asynchronous pads.

---
 rtl/i2s_volume_ctrl.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/i2s_volume_ctrl.sv
// Button-driven volume level for the I2S sample path: per-button sync + debounce, hold/auto-repeat
// FSM and a saturating level. Define VOL_MUTE_EN to make a two-button press from IDLE toggle mute.

module i2s_vol_debounce #(
  parameter int DEBOUNCE_CYC = 250000,
  parameter int CW           = 18
) (
  input  logic clk25,
  input  logic reset_n,
  input  logic btn_n,
  output logic db_n
);
  logic [1:0]    sync_q;
  logic [CW-1:0] cnt;

  // Counter only runs while the synchronized pad disagrees with the accepted state.
  always_ff @(posedge clk25 or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= 2'b11;
      cnt    <= '0;
      db_n   <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], btn_n};
      if (sync_q[1] == db_n) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYC-1)) begin
        db_n <= sync_q[1];
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module i2s_volume_ctrl #(
  parameter int DEBOUNCE_CYC = 250000,
  parameter int REPEAT_DELAY = 12500000,
  parameter int REPEAT_RATE  = 2500000,
  parameter int VOL_MAX      = 15,
  parameter int VOL_DEFAULT  = 12
) (
  input  logic       clk25,
  input  logic       reset_n,
  input  logic       btn_minus_n,
  input  logic       btn_plus_n,
  output logic [3:0] vol_level,
  output logic       vol_changed,
  output logic       mute
);
  localparam int NUM_BTN = 2;
  localparam int TMAX    = (REPEAT_DELAY > DEBOUNCE_CYC) ? REPEAT_DELAY : DEBOUNCE_CYC;
  localparam int TW      = $clog2(TMAX + 1);

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT, LOCK} state_t;
  typedef enum logic [1:0] {REQ_NONE, REQ_UP, REQ_DN, REQ_BOTH} req_t;

  state_t             state, state_nxt;
  req_t               req, held_req;
  logic [TW-1:0]      timer;
  logic [NUM_BTN-1:0] btn_raw, btn_db_n;
  logic               delay_hit, rate_hit, step, step_up, lock_entry;

  assign btn_raw = {btn_plus_n, btn_minus_n};  // [1] plus, [0] minus

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    i2s_vol_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .CW(TW)) u_db (
      .clk25  (clk25),
      .reset_n(reset_n),
      .btn_n  (btn_raw[g]),
      .db_n   (btn_db_n[g])
    );
  end

  always_comb begin
    case (btn_db_n)
      2'b01:   req = REQ_UP;
      2'b10:   req = REQ_DN;
      2'b00:   req = REQ_BOTH;
      default: req = REQ_NONE;
    endcase
  end

  assign delay_hit = (timer == TW'(REPEAT_DELAY-1));
  assign rate_hit  = (timer == TW'(REPEAT_RATE-1));

  // State register; timer clears on every state change so it can never overflow.
  always_ff @(posedge clk25 or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      timer    <= '0;
      held_req <= REQ_NONE;
    end else begin
      state <= state_nxt;
      if (state == IDLE) held_req <= req;
      if (state_nxt != state || (state == REPEAT && rate_hit)) timer <= '0;
      else if (state == HOLD || state == REPEAT)                timer <= timer + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req == REQ_UP || req == REQ_DN) state_nxt = HOLD;
        else if (req == REQ_BOTH)           state_nxt = LOCK;
      end
      HOLD, REPEAT: begin
        if (req != held_req)                state_nxt = (req == REQ_BOTH) ? LOCK : IDLE;
        else if (state == HOLD && delay_hit) state_nxt = REPEAT;
      end
      LOCK:    if (req == REQ_NONE) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    step       = 1'b0;
    step_up    = (req == REQ_UP);
    lock_entry = (state == IDLE) && (req == REQ_BOTH);
    case (state)
      IDLE:    step = (req == REQ_UP) || (req == REQ_DN);
      HOLD:    step = (req == held_req) && delay_hit;
      REPEAT:  step = (req == held_req) && rate_hit;
      default: step = 1'b0;
    endcase
  end

  // Level and strobe share one register stage so readback always sees them together.
  always_ff @(posedge clk25 or negedge reset_n) begin
    if (!reset_n) begin
      vol_level   <= 4'(VOL_DEFAULT);
      vol_changed <= 1'b0;
    end else begin
      vol_changed <= 1'b0;
      if (step && step_up && vol_level != 4'(VOL_MAX)) begin
        vol_level   <= vol_level + 4'd1;
        vol_changed <= 1'b1;
      end else if (step && !step_up && vol_level != 4'd0) begin
        vol_level   <= vol_level - 4'd1;
        vol_changed <= 1'b1;
      end
`ifdef VOL_MUTE_EN
      if (lock_entry || (step && mute)) vol_changed <= 1'b1;
`endif
    end
  end

`ifdef VOL_MUTE_EN
  always_ff @(posedge clk25 or negedge reset_n) begin
    if (!reset_n)        mute <= 1'b0;
    else if (lock_entry) mute <= ~mute;
    else if (step)       mute <= 1'b0;
  end
`else
  assign mute = 1'b0;
`endif
endmodule
